voting_booth_arbiter: RTL and testbench

//  Shares one voting booth among NREQ requesters. Each requester presents an age.

---
 rtl/voting_booth_arbiter.sv | 162 ++++++++++++++++
 tb/tb_voting_booth_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/voting_booth_arbiter.sv
// Round-robin scheduler for a single voting booth: picks a requester, screens its age,
// then holds the booth for VOTE_CYCLES cycles or pulses a reject.
module voting_booth_arbiter #(
  parameter int NREQ        = 4,
  parameter int AGE_W       = 8,
  parameter int MIN_AGE     = 18,
  parameter int CAND_AGE    = 31,
  parameter int VOTE_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*AGE_W-1:0] age_flat,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       reject,
  output logic                  candidate,
  output logic                  done,
  output logic                  aborted,
  output logic                  busy,
  output logic [15:0]           votes_total
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int CNT_W = (VOTE_CYCLES > 1) ? $clog2(VOTE_CYCLES) : 1;
  localparam logic [AGE_W-1:0] MIN_A  = AGE_W'(MIN_AGE);
  localparam logic [AGE_W-1:0] CAND_A = AGE_W'(CAND_AGE);

  typedef enum logic [1:0] {IDLE, CHECK, VOTE} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  sel_q, sel_d, last_q, last_d;
  logic [AGE_W-1:0]  age_q, age_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NREQ-1:0]   grant_q, grant_d, reject_q, reject_d;
  logic              cand_q, cand_d, done_q, done_d, abort_q, abort_d;
  logic [15:0]       votes_q, votes_d;

  logic [IDX_W-1:0]  pick, cand_idx;
  logic              found;
  logic [AGE_W-1:0]  age_pick;
  logic [NREQ-1:0]   sel_oh;

  // Search starts one past the last served requester and wraps.
  always_comb begin
    pick     = sel_q;
    cand_idx = '0;
    found    = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      cand_idx = IDX_W'((int'(last_q) + 1 + i) % NREQ);
      if (!found && req[cand_idx]) begin
        found = 1'b1;
        pick  = cand_idx;
      end
    end
  end

  always_comb begin
    age_pick = '0;
    for (int i = 0; i < NREQ; i++)
      if (pick == IDX_W'(i)) age_pick = age_flat[i*AGE_W +: AGE_W];
  end

  always_comb begin
    sel_oh        = '0;
    sel_oh[sel_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      last_q   <= IDX_W'(NREQ - 1);
      age_q    <= '0;
      cnt_q    <= '0;
      grant_q  <= '0;
      reject_q <= '0;
      cand_q   <= 1'b0;
      done_q   <= 1'b0;
      abort_q  <= 1'b0;
      votes_q  <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      last_q   <= last_d;
      age_q    <= age_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      reject_q <= reject_d;
      cand_q   <= cand_d;
      done_q   <= done_d;
      abort_q  <= abort_d;
      votes_q  <= votes_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req) state_d = CHECK;
      CHECK:   state_d = (age_q < MIN_A) ? IDLE : VOTE;
      VOTE:    if (!req[sel_q] || cnt_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sel_d    = sel_q;
    last_d   = last_q;
    age_d    = age_q;
    cnt_d    = cnt_q;
    grant_d  = grant_q;
    cand_d   = cand_q;
    reject_d = '0;
    done_d   = 1'b0;
    abort_d  = 1'b0;
    votes_d  = votes_q;
    case (state_q)
      IDLE: if (|req) begin
        sel_d = pick;
        age_d = age_pick;
      end
      CHECK: begin
        if (age_q < MIN_A) begin
          reject_d = sel_oh;
          last_d   = sel_q;
        end else begin
          grant_d = sel_oh;
          cand_d  = (age_q >= CAND_A);
          cnt_d   = CNT_W'(VOTE_CYCLES - 1);
        end
      end
      VOTE: begin
        // Owner dropping its request ends the vote early and is not counted.
        if (!req[sel_q]) begin
          grant_d = '0;
          cand_d  = 1'b0;
          done_d  = 1'b1;
          abort_d = 1'b1;
          last_d  = sel_q;
        end else if (cnt_q == '0) begin
          grant_d = '0;
          cand_d  = 1'b0;
          done_d  = 1'b1;
          last_d  = sel_q;
          if (votes_q != 16'hFFFF) votes_d = votes_q + 16'd1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign grant       = grant_q;
  assign reject      = reject_q;
  assign candidate   = cand_q;
  assign done        = done_q;
  assign aborted     = abort_q;
  assign busy        = (state_q != IDLE);
  assign votes_total = votes_q;

endmodule

// File: tb/tb_voting_booth_arbiter.sv
// Bench for voting_booth_arbiter: directed table, multi-cycle sequences, and random
// traffic scored against an edge-timestamp model of the booth.
module tb_voting_booth_arbiter;

  localparam int NREQ = 4, AGE_W = 8, MIN_AGE = 18, CAND_AGE = 31, VOTE_CYCLES = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*AGE_W-1:0] age_flat = '0;
  logic [NREQ-1:0]   grant, reject;
  logic              candidate, done, aborted, busy;
  logic [15:0]       votes_total;

  voting_booth_arbiter #(.NREQ(NREQ), .AGE_W(AGE_W), .MIN_AGE(MIN_AGE),
                         .CAND_AGE(CAND_AGE), .VOTE_CYCLES(VOTE_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .age_flat(age_flat),
    .grant(grant), .reject(reject), .candidate(candidate), .done(done),
    .aborted(aborted), .busy(busy), .votes_total(votes_total));

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;

  typedef struct { int who; int age; bit exp_rej; bit exp_cand; } vec_t;
  vec_t tbl[7];

  // reference model state: who holds/awaits the booth and when it was granted
  int m_owner, m_age, m_grant_edge, m_last, m_votes, k;
  bit m_granted;
  logic [NREQ-1:0] e_grant, e_reject;
  bit e_cand, e_done, e_abort;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [NREQ-1:0] oh(input int w);
    logic [NREQ-1:0] one = 1;
    return one << w;
  endfunction

  task automatic set_age(input int i, input int v);
    age_flat[i*AGE_W +: AGE_W] = AGE_W'(v);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    age_flat = '0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic model_release();
    e_grant = '0;
    e_cand = 1'b0;
    e_done = 1'b1;
    m_last = m_owner;
    m_owner = -1;
    m_granted = 1'b0;
  endtask

  // Called at each rising edge with the inputs the DUT sees at that edge.
  task automatic model_step();
    e_reject = '0;
    e_done = 1'b0;
    e_abort = 1'b0;
    if (m_owner >= 0 && !m_granted) begin
      if (m_age < MIN_AGE) begin
        e_reject = oh(m_owner);
        m_last = m_owner;
        m_owner = -1;
      end else begin
        m_granted = 1'b1;
        m_grant_edge = k;
        e_grant = oh(m_owner);
        e_cand = (m_age >= CAND_AGE);
      end
    end else if (m_owner >= 0) begin
      if (!req[m_owner]) begin
        e_abort = 1'b1;
        model_release();
      end else if (k - m_grant_edge == VOTE_CYCLES) begin
        if (m_votes < 65535) m_votes++;
        model_release();
      end
    end else if (|req) begin
      for (int off = 1; off <= NREQ; off++) begin
        int p;
        p = (m_last + off) % NREQ;
        if (m_owner < 0 && req[p]) begin
          m_owner = p;
          m_age = int'(age_flat[p*AGE_W +: AGE_W]);
          m_granted = 1'b0;
        end
      end
    end
    k++;
  endtask

  function automatic int rand_age();
    int b[6] = '{17, 18, 30, 31, 0, 255};
    if ($urandom_range(1) == 0) return int'($urandom_range(255));
    return b[$urandom_range(5)];
  endfunction

  initial begin
    tbl[0] = '{0, 17,  1'b1, 1'b0};
    tbl[1] = '{0, 25,  1'b0, 1'b0};
    tbl[2] = '{1, 17,  1'b1, 1'b0};
    tbl[3] = '{1, 18,  1'b0, 1'b0};
    tbl[4] = '{1, 30,  1'b0, 1'b0};
    tbl[5] = '{1, 31,  1'b0, 1'b1};
    tbl[6] = '{1, 255, 1'b0, 1'b1};

    // reset state
    do_reset();
    chk("rst_outs", {grant, reject, candidate, done, aborted, busy}, '0);
    chk("rst_votes", votes_total, 0);

    // single-request table: classification, latency, vote length
    foreach (tbl[n]) begin
      do_reset();
      req = oh(tbl[n].who);
      set_age(tbl[n].who, tbl[n].age);
      tick(2);
      chk($sformatf("tbl%0d_reject", n), reject, tbl[n].exp_rej ? oh(tbl[n].who) : '0);
      chk($sformatf("tbl%0d_grant", n), grant, tbl[n].exp_rej ? '0 : oh(tbl[n].who));
      chk($sformatf("tbl%0d_cand", n), candidate, tbl[n].exp_cand);
      if (tbl[n].exp_rej) begin
        req = '0;
        tick(1);
        chk($sformatf("tbl%0d_after_rej", n), {grant, reject, done, votes_total}, '0);
      end else begin
        tick(2);
        chk($sformatf("tbl%0d_grant_hold", n), {grant, done}, {oh(tbl[n].who), 1'b0});
        tick(1);
        chk($sformatf("tbl%0d_done", n), {grant, candidate, done, aborted}, {4'b0, 1'b0, 1'b1, 1'b0});
        chk($sformatf("tbl%0d_votes", n), votes_total, 1);
        req = '0;
        tick(1);
        chk($sformatf("tbl%0d_done_pulse", n), done, 0);
      end
    end

    // all four requesting, held: strict rotation, one grant every 5 edges
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < NREQ; i++) set_age(i, 40);
    tick(2);
    for (int g = 0; g < 5; g++) begin
      chk($sformatf("rr_grant%0d", g), {grant, candidate}, {oh(g % NREQ), 1'b1});
      tick(5);
    end

    // owner drops request after first grant cycle
    do_reset();
    req = 4'b0100;
    set_age(2, 20);
    tick(2);
    chk("abort_grant", grant, 4'b0100);
    req = '0;
    tick(1);
    chk("abort_pulse", {grant, done, aborted}, {4'b0, 1'b1, 1'b1});
    chk("abort_votes", votes_total, 0);
    tick(1);
    chk("abort_clear", {done, aborted, busy}, 3'b000);

    // asynchronous reset in the middle of a vote
    do_reset();
    req = 4'b0001;
    set_age(0, 25);
    tick(3);
    chk("rstmid_pre", grant, 4'b0001);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_async", {grant, done, busy, votes_total}, '0);
    req = 4'b1010;
    set_age(1, 40);
    set_age(3, 40);
    tick(1);
    rst_n = 1'b1;
    tick(2);
    chk("rstmid_first", grant, 4'b0010);

    // random traffic against the model
    do_reset();
    m_owner = -1; m_last = NREQ - 1; m_votes = 0; m_granted = 1'b0; k = 0;
    e_grant = '0; e_reject = '0; e_cand = 1'b0; e_done = 1'b0; e_abort = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (e_reject[i] || (e_done && m_last == i)) req[i] = 1'b0;
        else if (e_grant[i] && $urandom_range(9) == 0) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(2) == 0) begin
          req[i] = 1'b1;
          set_age(i, rand_age());
        end
      end
      @(posedge clk);
      model_step();
      #1;
      chk("rand", {grant, reject, candidate, done, aborted, busy, votes_total},
          {e_grant, e_reject, e_cand, e_done, e_abort, (m_owner >= 0), 16'(m_votes)});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
